// File: rtl/multi_alarm_clock_pkg.sv
// Shared types and constants for the multi-alarm clock: ring states,
// time limits, 7-segment digit patterns and small wrap-around helpers.
package multi_alarm_clock_pkg;

  typedef enum logic [1:0] {
    RS_IDLE    = 2'd0,
    RS_RINGING = 2'd1,
    RS_SNOOZED = 2'd2
  } ring_state_e;

  localparam logic [4:0] HOUR_MAX = 5'd23;
  localparam logic [5:0] MIN_MAX  = 6'd59;
  localparam logic [5:0] SEC_MAX  = 6'd59;

  // Active-high gfedcba patterns, element d is the pattern for digit d
  localparam logic [9:0][6:0] SEG7_DIGIT = {
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] seg7(input logic [3:0] d);
    return (d <= 4'd9) ? SEG7_DIGIT[d] : 7'h00;
  endfunction

  function automatic logic [4:0] inc_hr(input logic [4:0] h);
    return (h == HOUR_MAX) ? 5'd0 : h + 5'd1;
  endfunction

  function automatic logic [5:0] inc_60(input logic [5:0] v);
    return (v == MIN_MAX) ? 6'd0 : v + 6'd1;
  endfunction

endpackage

// File: rtl/multi_alarm_clock_bin2seg7.sv
// Binary 0..59 to two 7-segment digits {tens, ones}; purely combinational.
module bin2seg7
  import multi_alarm_clock_pkg::*;
(
  input  logic [5:0]  bin_i,
  output logic [13:0] seg_o
);

  logic [3:0] tens;
  logic [3:0] ones;

  always_comb begin
    tens  = 4'(bin_i / 6'd10);
    ones  = 4'(bin_i % 6'd10);
    seg_o = {seg7(tens), seg7(ones)};
  end

endmodule

// File: rtl/multi_alarm_clock.sv
// Time-of-day clock with NUM_ALARMS alarms, snooze, auto-stop ring and
// 12/24-hour 7-segment display.
module multi_alarm_clock
  import multi_alarm_clock_pkg::*;
#(
  parameter int CLK_PER_SEC = 10,
  parameter int NUM_ALARMS  = 4,
  parameter int SNOOZE_MIN  = 5,
  parameter int RING_SEC    = 60,
  localparam int SEL_W      = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  set_time,
  input  logic                  alarm_set,
  input  logic [SEL_W-1:0]      alarm_sel,
  input  logic [NUM_ALARMS-1:0] alarm_en,
  input  logic                  hours_set,
  input  logic                  mins_set,
  input  logic                  mode_24h,
  input  logic                  snooze,
  output logic [13:0]           hours_disp,
  output logic [13:0]           mins_disp,
  output logic                  AM_PM_disp,
  output logic                  Speaker_out,
  output logic [NUM_ALARMS-1:0] alarm_active
);

  localparam int DIV_W = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_PER_SEC - 1);
  localparam logic [5:0]       RING_LAST  = 6'(RING_SEC - 1);
  localparam logic [6:0]       SNOOZE_ADD = 7'(SNOOZE_MIN);
  localparam logic [SEL_W:0]   NUM_A      = (SEL_W+1)'(NUM_ALARMS);

  logic [DIV_W-1:0] div_q, div_d;
  logic [4:0]       hour_q, hour_d;
  logic [5:0]       min_q, min_d, sec_q, sec_d;
  logic [NUM_ALARMS-1:0][4:0] al_hr_q, al_hr_d;
  logic [NUM_ALARMS-1:0][5:0] al_min_q, al_min_d;
  logic [1:0]       hs_q, ms_q, sn_q;
  logic             h_rise, m_rise, sn_rise;
  logic             tick, sec_wrap, sel_ok;

  ring_state_e      state_q;
  logic [SEL_W-1:0] k_q;
  logic [5:0]       ring_cnt_q;
  logic [4:0]       wake_hr_q;
  logic [5:0]       wake_min_q;
  logic             spk_q;
  logic [NUM_ALARMS-1:0] act_q;

  // Two-stage capture; the increment lands one cycle after the edge is seen
  assign h_rise  = hs_q[0] & ~hs_q[1];
  assign m_rise  = ms_q[0] & ~ms_q[1];
  assign sn_rise = sn_q[0] & ~sn_q[1];
  assign sel_ok  = ({1'b0, alarm_sel} < NUM_A);

  always_comb begin
    div_d    = div_q;
    sec_d    = sec_q;
    min_d    = min_q;
    hour_d   = hour_q;
    al_hr_d  = al_hr_q;
    al_min_d = al_min_q;
    tick     = 1'b0;
    if (set_time) begin
      div_d = '0;
      sec_d = '0;
      if (h_rise) hour_d = inc_hr(hour_q);
      if (m_rise) min_d  = inc_60(min_q);
    end else begin
      tick  = (div_q == DIV_LAST);
      div_d = tick ? '0 : div_q + DIV_W'(1);
      if (tick) begin
        sec_d = inc_60(sec_q);
        if (sec_q == SEC_MAX) begin
          min_d = inc_60(min_q);
          if (min_q == MIN_MAX) hour_d = inc_hr(hour_q);
        end
      end
      if (alarm_set && sel_ok) begin
        if (h_rise) al_hr_d[alarm_sel]  = inc_hr(al_hr_q[alarm_sel]);
        if (m_rise) al_min_d[alarm_sel] = inc_60(al_min_q[alarm_sel]);
      end
    end
  end

  assign sec_wrap = tick && (sec_q == SEC_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q    <= '0;
      hour_q   <= '0;
      min_q    <= '0;
      sec_q    <= '0;
      al_hr_q  <= '0;
      al_min_q <= '0;
      hs_q     <= '0;
      ms_q     <= '0;
      sn_q     <= '0;
    end else begin
      div_q    <= div_d;
      hour_q   <= hour_d;
      min_q    <= min_d;
      sec_q    <= sec_d;
      al_hr_q  <= al_hr_d;
      al_min_q <= al_min_d;
      hs_q     <= {hs_q[0], hours_set};
      ms_q     <= {ms_q[0], mins_set};
      sn_q     <= {sn_q[0], snooze};
    end
  end

  // Match is taken against the time the current tick is about to produce
  logic             hit;
  logic [SEL_W-1:0] hit_idx;

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (alarm_en[i] && al_hr_q[i] == hour_d && al_min_q[i] == min_d) begin
        hit     = 1'b1;
        hit_idx = SEL_W'(i);
      end
    end
  end

  logic [6:0] wsum;
  logic [4:0] wake_hr_n;
  logic [5:0] wake_min_n;

  always_comb begin
    wsum = {1'b0, min_q} + SNOOZE_ADD;
    if (wsum >= 7'd60) begin
      wake_min_n = 6'(wsum - 7'd60);
      wake_hr_n  = inc_hr(hour_q);
    end else begin
      wake_min_n = wsum[5:0];
      wake_hr_n  = hour_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RS_IDLE;
      k_q        <= '0;
      ring_cnt_q <= '0;
      wake_hr_q  <= '0;
      wake_min_q <= '0;
      spk_q      <= 1'b0;
      act_q      <= '0;
    end else begin
      case (state_q)
        RS_IDLE: begin
          spk_q <= 1'b0;
          if (sec_wrap && !alarm_set && hit) begin
            state_q    <= RS_RINGING;
            k_q        <= hit_idx;
            act_q      <= NUM_ALARMS'(1) << hit_idx;
            ring_cnt_q <= '0;
            spk_q      <= 1'b1;
          end
        end
        RS_RINGING: begin
          if (!alarm_en[k_q] || set_time || alarm_set) begin
            state_q <= RS_IDLE;
            spk_q   <= 1'b0;
            act_q   <= '0;
          end else if (sn_rise) begin
            state_q    <= RS_SNOOZED;
            spk_q      <= 1'b0;
            wake_hr_q  <= wake_hr_n;
            wake_min_q <= wake_min_n;
          end else if (tick && ring_cnt_q == RING_LAST) begin
            state_q <= RS_IDLE;
            spk_q   <= 1'b0;
            act_q   <= '0;
          end else begin
            spk_q <= ~spk_q;
            if (tick) ring_cnt_q <= ring_cnt_q + 6'd1;
          end
        end
        RS_SNOOZED: begin
          spk_q <= 1'b0;
          if (!alarm_en[k_q]) begin
            state_q <= RS_IDLE;
            act_q   <= '0;
          end else if (sec_wrap && hour_d == wake_hr_q && min_d == wake_min_q) begin
            state_q    <= RS_RINGING;
            ring_cnt_q <= '0;
            spk_q      <= 1'b1;
          end
        end
        default: begin
          state_q <= RS_IDLE;
          spk_q   <= 1'b0;
          act_q   <= '0;
        end
      endcase
    end
  end

  assign Speaker_out  = spk_q;
  assign alarm_active = act_q;

  logic [4:0] dh, dh12;
  logic [5:0] dm;
  logic       pm;

  always_comb begin
    if (alarm_set && !set_time) begin
      dh = sel_ok ? al_hr_q[alarm_sel]  : '0;
      dm = sel_ok ? al_min_q[alarm_sel] : '0;
    end else begin
      dh = hour_q;
      dm = min_q;
    end
    pm   = 1'b0;
    dh12 = dh;
    if (!mode_24h) begin
      pm = (dh >= 5'd12);
      if (dh == 5'd0)       dh12 = 5'd12;
      else if (dh > 5'd12)  dh12 = dh - 5'd12;
    end
  end

  assign AM_PM_disp = pm;

  bin2seg7 u_hr_seg  (.bin_i({1'b0, dh12}), .seg_o(hours_disp));
  bin2seg7 u_min_seg (.bin_i(dm),           .seg_o(mins_disp));

endmodule

// File: tb/tb_multi_alarm_clock.sv
// Randomized self-checking bench for multi_alarm_clock; the reference keeps
// time as seconds-of-day derived from cycles elapsed since the last release.
module tb_multi_alarm_clock;

  localparam int CPS = 10;

  logic        clk = 1'b0;
  logic        reset_n, set_time, alarm_set, hours_set, mins_set, mode_24h, snooze;
  logic [1:0]  alarm_sel;
  logic [3:0]  alarm_en;
  logic [13:0] hours_disp, mins_disp;
  logic        AM_PM_disp, Speaker_out;
  logic [3:0]  alarm_active;

  int errors = 0;
  int checks = 0;

  int unsigned ncyc = 0;
  int unsigned ncyc_rel = 0;
  int base_tod = 0;
  bit running = 0;
  int al_h[4];
  int al_m[4];

  multi_alarm_clock #(.CLK_PER_SEC(CPS), .NUM_ALARMS(4), .SNOOZE_MIN(5), .RING_SEC(60)) dut (
    .clk(clk), .reset_n(reset_n), .set_time(set_time), .alarm_set(alarm_set),
    .alarm_sel(alarm_sel), .alarm_en(alarm_en), .hours_set(hours_set),
    .mins_set(mins_set), .mode_24h(mode_24h), .snooze(snooze),
    .hours_disp(hours_disp), .mins_disp(mins_disp), .AM_PM_disp(AM_PM_disp),
    .Speaker_out(Speaker_out), .alarm_active(alarm_active)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ncyc++;

  function automatic logic [6:0] dig(input int d);
    case (d)
      0: return 7'h3F; 1: return 7'h06; 2: return 7'h5B; 3: return 7'h4F; 4: return 7'h66;
      5: return 7'h6D; 6: return 7'h7D; 7: return 7'h07; 8: return 7'h7F; 9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [13:0] seg2(input int v);
    return {dig(v / 10), dig(v % 10)};
  endfunction

  function automatic int disp_hour(input int h, input logic m24);
    if (m24) return h;
    if (h == 0) return 12;
    return (h > 12) ? h - 12 : h;
  endfunction

  function automatic logic exp_pm(input int h, input logic m24);
    return !m24 && (h >= 12);
  endfunction

  function automatic int now_tod();
    if (!running) return base_tod;
    return (base_tod + int'((ncyc - ncyc_rel) / CPS)) % 86400;
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int which);
    case (which)
      0: hours_set = 1'b1;
      1: mins_set  = 1'b1;
      default: snooze = 1'b1;
    endcase
    step(2);
    hours_set = 1'b0; mins_set = 1'b0; snooze = 1'b0;
    step(2);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    set_time = 0; alarm_set = 0; alarm_sel = 0; alarm_en = 0;
    hours_set = 0; mins_set = 0; snooze = 0;
    step(3);
    reset_n = 1'b1;
    base_tod = 0; ncyc_rel = ncyc; running = 1;
    for (int k = 0; k < 4; k++) begin al_h[k] = 0; al_m[k] = 0; end
  endtask

  // Leaves set_time high; the clock is frozen at h:m:00
  task automatic set_clock(input int h, input int m);
    int tod, ch, cm;
    tod = now_tod();
    ch = tod / 3600; cm = (tod / 60) % 60;
    alarm_set = 1'b0;
    set_time  = 1'b1;
    running   = 0;
    repeat ((h - ch + 24) % 24) pulse(0);
    repeat ((m - cm + 60) % 60) pulse(1);
    base_tod = h * 3600 + m * 60;
  endtask

  task automatic release_clock();
    set_time = 1'b0;
    ncyc_rel = ncyc;
    running  = 1;
  endtask

  task automatic set_alarm(input int k, input int h, input int m);
    alarm_set = 1'b1;
    alarm_sel = 2'(k);
    repeat ((h - al_h[k] + 24) % 24) pulse(0);
    repeat ((m - al_m[k] + 60) % 60) pulse(1);
    al_h[k] = h; al_m[k] = m;
  endtask

  task automatic test_reset();
    mode_24h = 1'b0;
    reset_n = 1'b0;
    set_time = 0; alarm_set = 0; alarm_sel = 0; alarm_en = 0;
    hours_set = 0; mins_set = 0; snooze = 0;
    step(2);
    checks++; if (hours_disp !== {7'h06, 7'h5B}) begin errors++; $display("FAIL reset_hours12 got %h want %h", hours_disp, {7'h06, 7'h5B}); end
    checks++; if (mins_disp !== {7'h3F, 7'h3F}) begin errors++; $display("FAIL reset_mins got %h want %h", mins_disp, {7'h3F, 7'h3F}); end
    checks++; if (AM_PM_disp !== 1'b0) begin errors++; $display("FAIL reset_ampm got %b want 0", AM_PM_disp); end
    checks++; if (Speaker_out !== 1'b0) begin errors++; $display("FAIL reset_speaker got %b want 0", Speaker_out); end
    checks++; if (alarm_active !== 4'b0) begin errors++; $display("FAIL reset_active got %b want 0000", alarm_active); end
    mode_24h = 1'b1;
    #1;
    checks++; if (hours_disp !== {7'h3F, 7'h3F}) begin errors++; $display("FAIL reset_hours24 got %h want %h", hours_disp, {7'h3F, 7'h3F}); end
    mode_24h = 1'b0;
    step(1);
    do_reset();
  endtask

  task automatic test_set_time();
    int h, m, r, tod;
    logic m24;
    mode_24h = 1'b0;
    set_clock(10, 20);
    checks++; if (hours_disp !== seg2(10)) begin errors++; $display("FAIL set_hours got %h want %h", hours_disp, seg2(10)); end
    checks++; if (mins_disp !== seg2(20)) begin errors++; $display("FAIL set_mins got %h want %h", mins_disp, seg2(20)); end
    checks++; if (AM_PM_disp !== 1'b0) begin errors++; $display("FAIL set_ampm got %b want 0", AM_PM_disp); end
    for (int it = 0; it < 5; it++) begin
      h = $urandom_range(0, 23); m = $urandom_range(0, 59);
      m24 = 1'($urandom_range(0, 1)); r = $urandom_range(0, 1500);
      mode_24h = m24;
      set_clock(h, m);
      checks++; if (hours_disp !== seg2(disp_hour(h, m24))) begin errors++; $display("FAIL rand_set_hours it%0d got %h want %h", it, hours_disp, seg2(disp_hour(h, m24))); end
      checks++; if (mins_disp !== seg2(m)) begin errors++; $display("FAIL rand_set_mins it%0d got %h want %h", it, mins_disp, seg2(m)); end
      release_clock();
      step(r);
      tod = now_tod();
      checks++; if (hours_disp !== seg2(disp_hour(tod / 3600, m24))) begin errors++; $display("FAIL run_hours it%0d got %h want %h", it, hours_disp, seg2(disp_hour(tod / 3600, m24))); end
      checks++; if (mins_disp !== seg2((tod / 60) % 60)) begin errors++; $display("FAIL run_mins it%0d got %h want %h", it, mins_disp, seg2((tod / 60) % 60)); end
      checks++; if (AM_PM_disp !== exp_pm(tod / 3600, m24)) begin errors++; $display("FAIL run_ampm it%0d got %b want %b", it, AM_PM_disp, exp_pm(tod / 3600, m24)); end
    end
  endtask

  task automatic test_rollover();
    mode_24h = 1'b0;
    set_clock(23, 59);
    release_clock();
    step(599);
    checks++; if (hours_disp !== seg2(11) || AM_PM_disp !== 1'b1) begin errors++; $display("FAIL pre_roll_hours got %h/%b want %h/1", hours_disp, AM_PM_disp, seg2(11)); end
    checks++; if (mins_disp !== seg2(59)) begin errors++; $display("FAIL pre_roll_mins got %h want %h", mins_disp, seg2(59)); end
    step(1);
    checks++; if (hours_disp !== seg2(12)) begin errors++; $display("FAIL roll_hours12 got %h want %h", hours_disp, seg2(12)); end
    checks++; if (AM_PM_disp !== 1'b0) begin errors++; $display("FAIL roll_ampm got %b want 0", AM_PM_disp); end
    checks++; if (mins_disp !== seg2(0)) begin errors++; $display("FAIL roll_mins got %h want %h", mins_disp, seg2(0)); end
    mode_24h = 1'b1;
    #1;
    checks++; if (hours_disp !== seg2(0)) begin errors++; $display("FAIL roll_hours24 got %h want %h", hours_disp, seg2(0)); end
    step(1);
  endtask

  task automatic test_alarm_ring();
    mode_24h = 1'b1;
    alarm_en = 4'b0000;
    set_alarm(0, 10, 23);
    checks++; if (hours_disp !== seg2(10) || mins_disp !== seg2(23)) begin errors++; $display("FAIL alarm_disp got %h:%h want %h:%h", hours_disp, mins_disp, seg2(10), seg2(23)); end
    alarm_en = 4'b0001;
    set_clock(10, 22);
    release_clock();
    step(599);
    checks++; if (alarm_active !== 4'b0 || Speaker_out !== 1'b0) begin errors++; $display("FAIL pre_ring got %b/%b want 0000/0", alarm_active, Speaker_out); end
    step(1);
    checks++; if (alarm_active !== 4'b0001) begin errors++; $display("FAIL ring_active got %b want 0001", alarm_active); end
    checks++; if (Speaker_out !== 1'b1) begin errors++; $display("FAIL ring_first got %b want 1", Speaker_out); end
    for (int i = 1; i < 8; i++) begin
      step(1);
      checks++; if (Speaker_out !== ((i % 2) == 0)) begin errors++; $display("FAIL ring_toggle c%0d got %b want %b", i, Speaker_out, (i % 2) == 0); end
    end
    step(592);
    checks++; if (alarm_active !== 4'b0001) begin errors++; $display("FAIL ring_last_cycle got %b want 0001", alarm_active); end
    step(1);
    checks++; if (alarm_active !== 4'b0 || Speaker_out !== 1'b0) begin errors++; $display("FAIL ring_autostop got %b/%b want 0000/0", alarm_active, Speaker_out); end
    checks++; if (mins_disp !== seg2(24)) begin errors++; $display("FAIL ring_stop_time got %h want %h", mins_disp, seg2(24)); end
  endtask

  task automatic test_priority_snooze();
    alarm_en = 4'b0000;
    set_alarm(1, 7, 0);
    set_alarm(2, 7, 0);
    alarm_en = 4'b0110;
    set_clock(6, 59);
    release_clock();
    step(600);
    checks++; if (alarm_active !== 4'b0010) begin errors++; $display("FAIL prio_active got %b want 0010", alarm_active); end
    checks++; if (Speaker_out !== 1'b1) begin errors++; $display("FAIL prio_speaker got %b want 1", Speaker_out); end
    step(300);
    pulse(2);
    checks++; if (Speaker_out !== 1'b0 || alarm_active !== 4'b0010) begin errors++; $display("FAIL snoozed got %b/%b want 0/0010", Speaker_out, alarm_active); end
    step(2695);
    checks++; if (Speaker_out !== 1'b0 || alarm_active !== 4'b0010) begin errors++; $display("FAIL pre_wake got %b/%b want 0/0010", Speaker_out, alarm_active); end
    step(1);
    checks++; if (Speaker_out !== 1'b1 || alarm_active !== 4'b0010) begin errors++; $display("FAIL wake_ring got %b/%b want 1/0010", Speaker_out, alarm_active); end
    checks++; if (mins_disp !== seg2(5)) begin errors++; $display("FAIL wake_time got %h want %h", mins_disp, seg2(5)); end
    alarm_en = 4'b0000;
    step(1);
    checks++; if (alarm_active !== 4'b0 || Speaker_out !== 1'b0) begin errors++; $display("FAIL en_stop got %b/%b want 0000/0", alarm_active, Speaker_out); end
  endtask

  task automatic test_random_alarms();
    int h, m, tgt, v;
    logic [3:0] en, exp_act;
    logic m24;
    for (int it = 0; it < 6; it++) begin
      h = $urandom_range(0, 23); m = $urandom_range(0, 59);
      tgt = (h * 60 + m + 1) % 1440;
      en = 4'($urandom_range(0, 15));
      m24 = 1'($urandom_range(0, 1));
      mode_24h = m24;
      alarm_en = en;
      for (int k = 0; k < 4; k++) begin
        v = ($urandom_range(0, 1) == 1) ? tgt : $urandom_range(0, 1439);
        set_alarm(k, v / 60, v % 60);
      end
      exp_act = 4'b0;
      for (int k = 3; k >= 0; k--)
        if (en[k] && (al_h[k] * 60 + al_m[k]) == tgt) exp_act = 4'(1) << k;
      set_clock(h, m);
      release_clock();
      step(599);
      checks++; if (alarm_active !== 4'b0) begin errors++; $display("FAIL rand_pre it%0d got %b want 0000", it, alarm_active); end
      step(1);
      checks++; if (alarm_active !== exp_act) begin errors++; $display("FAIL rand_active it%0d got %b want %b", it, alarm_active, exp_act); end
      checks++; if (Speaker_out !== (exp_act != 0)) begin errors++; $display("FAIL rand_speaker it%0d got %b want %b", it, Speaker_out, exp_act != 0); end
      checks++; if (hours_disp !== seg2(disp_hour(tgt / 60, m24)) || AM_PM_disp !== exp_pm(tgt / 60, m24)) begin
        errors++; $display("FAIL rand_hours it%0d got %h/%b want %h/%b", it, hours_disp, AM_PM_disp, seg2(disp_hour(tgt / 60, m24)), exp_pm(tgt / 60, m24));
      end
    end
  endtask

  task automatic test_reset_mid_ring();
    alarm_en = 4'b1000;
    set_alarm(3, 0, 1);
    set_clock(0, 0);
    release_clock();
    step(600);
    checks++; if (Speaker_out !== 1'b1 || alarm_active !== 4'b1000) begin errors++; $display("FAIL mid_ring_pre got %b/%b want 1/1000", Speaker_out, alarm_active); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (Speaker_out !== 1'b0) begin errors++; $display("FAIL async_speaker got %b want 0", Speaker_out); end
    checks++; if (alarm_active !== 4'b0) begin errors++; $display("FAIL async_active got %b want 0000", alarm_active); end
    step(2);
    do_reset();
  endtask

  initial begin
    test_reset();
    test_set_time();
    test_rollover();
    test_alarm_ring();
    test_priority_snooze();
    test_random_alarms();
    test_reset_mid_ring();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multi_alarm_clock.md
MULTI_ALARM_CLOCK -- requirements
Module: multi_alarm_clock

Interface
REQ-001 Parameter CLK_PER_SEC, default 10, clk cycles per second (>=1).
REQ-002 Parameter NUM_ALARMS, default 4, independent alarm registers (1..8).
REQ-003 Parameter SNOOZE_MIN, default 5, snooze delay in minutes (1..59).
REQ-004 Parameter RING_SEC, default 60, auto-stop ring duration in seconds (1..59 or 60).
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 set_time  in  1  level; time-set mode.
REQ-008 alarm_set  in  1  level; alarm-set mode for alarm selected by alarm_sel.
REQ-009 alarm_sel  in  max(1,$clog2(NUM_ALARMS))  alarm index to set/display.
REQ-010 alarm_en  in  NUM_ALARMS  per-alarm enable level.
REQ-011 hours_set, mins_set  in  1 each  increment requests, rising-edge detected internally.
REQ-012 mode_24h  in  1  1 = 24-hour display, 0 = 12-hour display.
REQ-013 snooze  in  1  rising-edge detected snooze request.
REQ-014 hours_disp, mins_disp  out  14 each  {tens[13:7], ones[6:0]} 7-segment, active-high, bit order gfedcba.
REQ-015 AM_PM_disp  out  1  1 = PM (12-hour mode only).
REQ-016 Speaker_out  out  1  ring tone.
REQ-017 alarm_active  out  NUM_ALARMS  one-hot index of ringing/snoozed alarm.

Function
REQ-018 Time kept internally as hour 0..23, min 0..59, sec 0..59; one second tick every CLK_PER_SEC cycles from a free-running divider.
REQ-019 On tick: sec wraps 59->0 with min carry; min 59->0 with hour carry; hour 23->0.
REQ-020 set_time high: divider and sec held at 0; hours_set edge -> hour+1 mod 24; mins_set edge -> min+1 mod 60 without hour carry; display shows time.
REQ-021 alarm_set high (set_time low): edges adjust alarm[alarm_sel] hour/min identically; display shows that alarm; time keeps running.
REQ-022 set_time has priority over alarm_set; simultaneous hours_set and mins_set edges both apply.
REQ-023 Edge detection: increment exactly once per 0->1 transition, one cycle after the edge is sampled.
REQ-024 12-hour display: hour 0->12 AM, 1..11 AM, 12 PM, 13..23 -> 1..11 PM; 24-hour display: 00..23, AM_PM_disp=0.
REQ-025 Digits: 0=7'h3F,1=06,2=5B,3=4F,4=66,5=6D,6=7D,7=07,8=7F,9=6F; tens digit not blanked.
REQ-026 Ring FSM states IDLE, RINGING, SNOOZED.
REQ-027 IDLE->RINGING on tick producing sec==0 when enabled alarm k equals hour:min, neither set mode active; lowest k wins on multiple matches.
REQ-028 RINGING: Speaker_out toggles every clk cycle, starting at 1; alarm_active=onehot(k).
REQ-029 RINGING->IDLE after RING_SEC ticks, or alarm_en[k] low, or set_time/alarm_set high.
REQ-030 RINGING->SNOOZED on snooze edge; wake time = current hour:min + SNOOZE_MIN, mod 24h.
REQ-031 SNOOZED: Speaker_out=0, alarm_active held; ->RINGING on tick producing sec==0 at wake time; ->IDLE if alarm_en[k] low.
REQ-032 Snooze edge in IDLE/SNOOZED ignored; new matches ignored unless IDLE.
REQ-033 Speaker_out=0 in IDLE and SNOOZED.

Reset
REQ-034 reset_n low: time 00:00:00, all alarms 00:00, divider 0, FSM IDLE, edge registers 0.
REQ-035 During/after reset: Speaker_out=0, alarm_active=0, AM_PM_disp=0; hours_disp={7'h06,7'h5B} (12-hour) or {7'h3F,7'h3F} (24-hour); mins_disp={7'h3F,7'h3F}.
REQ-036 Reset mid-ring stops Speaker_out asynchronously.

Structure
REQ-037 Package multi_alarm_clock_pkg holds ring-state enum, 7-segment digit constants, hour/min/sec limits.
REQ-038 One sub-module bin2seg7: binary 0..59 in, 14-bit two-digit 7-segment out, combinational, instantiated for hours and minutes.

Verification (CLK_PER_SEC=10)
REQ-039 Reset, set_time=1, 10 hours_set pulses, 20 mins_set pulses, mode_24h=0 -> display 10:20, AM_PM_disp=0.
REQ-040 Time 23:59:59, one tick -> 00:00:00; 12-hour display "12", AM_PM_disp=0.
REQ-041 Alarm0=10:23, alarm_en=1, time 10:22:59 -> at next tick RINGING, alarm_active=4'b0001, Speaker_out toggles; stops after 60 s.
REQ-042 Alarms 1 and 2 both 07:00 enabled -> alarm_active=4'b0010 only.
REQ-043 Ringing at 07:00, snooze edge at 07:00:30 -> silent, re-ring at 07:05:00.
REQ-044 Reset asserted during RINGING -> Speaker_out=0 and alarm_active=0 same cycle.
